// File: rtl/window3x3_gen_pkg.sv
// Shared constants and types for the 3x3 window generator.
// Counter width is sized for the largest supported image dimension.
package window3x3_gen_pkg;

   localparam int DATA_W_DEF     = 8;
   localparam int IMG_WIDTH_DEF  = 640;
   localparam int IMG_HEIGHT_DEF = 480;
   localparam int MAX_DIM        = 4096;
   localparam int CNT_W          = $clog2(MAX_DIM);

   typedef logic [CNT_W-1:0] cnt_t;

   function automatic cnt_t cnt_last(input int n);
      return cnt_t'(n - 1);
   endfunction

endpackage

// File: rtl/window3x3_gen_if.sv
// Pixel stream in, 3x3 window out. FRAME_SYNC_EN adds the sof input.
// pix1..pix3 oldest line, pix7..pix9 newest; pix9 is the newest pixel.
interface window3x3_gen_if
   import window3x3_gen_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF
);

   logic              in_valid;
   logic [DATA_W-1:0] in_pix;
`ifdef FRAME_SYNC_EN
   logic              sof;
`endif
   logic [DATA_W-1:0] pix1, pix2, pix3;
   logic [DATA_W-1:0] pix4, pix5, pix6;
   logic [DATA_W-1:0] pix7, pix8, pix9;
   logic              out_valid;

   modport master (
`ifdef FRAME_SYNC_EN
      output sof,
`endif
      output in_valid, in_pix,
      input  pix1, pix2, pix3,
      input  pix4, pix5, pix6,
      input  pix7, pix8, pix9,
      input  out_valid
   );

   modport slave (
`ifdef FRAME_SYNC_EN
      input  sof,
`endif
      input  in_valid, in_pix,
      output pix1, pix2, pix3,
      output pix4, pix5, pix6,
      output pix7, pix8, pix9,
      output out_valid
   );

endinterface

// File: rtl/window3x3_gen_line_buf.sv
// Single-port line memory: combinational read and write at the same
// index, so a read returns the old value (read-before-write). Not reset.
module line_buf #(
   parameter int DEPTH  = 640,
   parameter int DATA_W = 8,
   parameter int AW     = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              we_i,
   input  logic [AW-1:0]     addr_i,
   input  logic [DATA_W-1:0] wdata_i,
   output logic [DATA_W-1:0] rdata_o
);

   logic [DATA_W-1:0] mem_q [DEPTH];

   assign rdata_o = mem_q[addr_i];

   always_ff @(posedge clk) begin
      if (we_i) mem_q[addr_i] <= wdata_i;
   end

endmodule

// File: rtl/window3x3_gen.sv
// Raster-order 3x3 sliding window generator with two line buffers.
// Optional `define FRAME_SYNC_EN enables sof realignment to (0,0).
module window3x3_gen
   import window3x3_gen_pkg::*;
#(
   parameter int IMG_WIDTH  = IMG_WIDTH_DEF,
   parameter int IMG_HEIGHT = IMG_HEIGHT_DEF,
   parameter int DATA_W     = DATA_W_DEF
) (
   input logic              clk,
   input logic              rst,
   window3x3_gen_if.slave   bus
);

   localparam int   AW       = $clog2(IMG_WIDTH);
   localparam cnt_t COL_LAST = cnt_last(IMG_WIDTH);
   localparam cnt_t ROW_LAST = cnt_last(IMG_HEIGHT);

   cnt_t              col_q, col_d;
   cnt_t              row_q, row_d;
   cnt_t              col_e, row_e;
   logic [DATA_W-1:0] win_q [9];
   logic [DATA_W-1:0] win_d [9];
   logic              ov_q, ov_d;
   logic              sof_hit;
   logic              we;
   logic [DATA_W-1:0] l1_rd, l2_rd;

`ifdef FRAME_SYNC_EN
   assign sof_hit = bus.in_valid & bus.sof;
`else
   assign sof_hit = 1'b0;
`endif

   // sof overrides the counters for this pixel only
   assign col_e = sof_hit ? '0 : col_q;
   assign row_e = sof_hit ? '0 : row_q;
   assign we    = bus.in_valid & ~rst;

   line_buf #(
      .DEPTH  (IMG_WIDTH),
      .DATA_W (DATA_W),
      .AW     (AW)
   ) u_lb1 (
      .clk     (clk),
      .we_i    (we),
      .addr_i  (col_e[AW-1:0]),
      .wdata_i (bus.in_pix),
      .rdata_o (l1_rd)
   );

   line_buf #(
      .DEPTH  (IMG_WIDTH),
      .DATA_W (DATA_W),
      .AW     (AW)
   ) u_lb2 (
      .clk     (clk),
      .we_i    (we),
      .addr_i  (col_e[AW-1:0]),
      .wdata_i (l1_rd),
      .rdata_o (l2_rd)
   );

   always_comb begin
      col_d = col_q;
      row_d = row_q;
      win_d = win_q;
      ov_d  = 1'b0;
      if (bus.in_valid) begin
         win_d[0] = win_q[1];
         win_d[1] = win_q[2];
         win_d[2] = l2_rd;
         win_d[3] = win_q[4];
         win_d[4] = win_q[5];
         win_d[5] = l1_rd;
         win_d[6] = win_q[7];
         win_d[7] = win_q[8];
         win_d[8] = bus.in_pix;
         ov_d = (row_e >= cnt_t'(2)) && (col_e >= cnt_t'(2));
         if (col_e == COL_LAST) begin
            col_d = '0;
            row_d = (row_e == ROW_LAST) ? '0 : row_e + cnt_t'(1);
         end else begin
            col_d = col_e + cnt_t'(1);
            row_d = row_e;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         col_q <= '0;
         row_q <= '0;
         ov_q  <= 1'b0;
         for (int i = 0; i < 9; i++) win_q[i] <= '0;
      end else begin
         col_q <= col_d;
         row_q <= row_d;
         ov_q  <= ov_d;
         win_q <= win_d;
      end
   end

   assign bus.pix1      = win_q[0];
   assign bus.pix2      = win_q[1];
   assign bus.pix3      = win_q[2];
   assign bus.pix4      = win_q[3];
   assign bus.pix5      = win_q[4];
   assign bus.pix6      = win_q[5];
   assign bus.pix7      = win_q[6];
   assign bus.pix8      = win_q[7];
   assign bus.pix9      = win_q[8];
   assign bus.out_valid = ov_q;

endmodule

// File: tb/tb_window3x3_gen.sv
// Self-checking bench for window3x3_gen on a 4x3 image.
// Reference model keeps the whole frame and extracts windows by position.
module tb_window3x3_gen;

   localparam int W = 4;
   localparam int H = 3;

   logic clk = 1'b0;
   logic rst = 1'b1;

   window3x3_gen_if #(.DATA_W(8)) bus ();

   window3x3_gen #(
      .IMG_WIDTH  (W),
      .IMG_HEIGHT (H),
      .DATA_W     (8)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial forever #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   int idx      = 0;
   int nwin     = 0;
   logic [7:0] img [H][W];
   logic [7:0] hist [3];

   function automatic logic [7:0] pix_at(input int k);
      case (k)
         1: return bus.pix1;
         2: return bus.pix2;
         3: return bus.pix3;
         4: return bus.pix4;
         5: return bus.pix5;
         6: return bus.pix6;
         7: return bus.pix7;
         8: return bus.pix8;
         default: return bus.pix9;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic step(input bit v, input logic [7:0] p, input bit s);
      int pos, r, c;
      bit exp_ov;
      @(negedge clk);
      bus.in_valid = v;
      bus.in_pix   = p;
`ifdef FRAME_SYNC_EN
      bus.sof      = s;
`endif
      @(posedge clk);
      #1;
      exp_ov = 1'b0;
      r = 0;
      c = 0;
      if (v) begin
         if (s) idx = 0;
         pos = idx % (W * H);
         r = pos / W;
         c = pos % W;
         img[r][c] = p;
         hist[0] = hist[1];
         hist[1] = hist[2];
         hist[2] = p;
         exp_ov = (r >= 2) && (c >= 2);
         idx++;
      end
      chk("out_valid", {31'd0, bus.out_valid}, {31'd0, exp_ov});
      chk("pix7", {24'd0, bus.pix7}, {24'd0, hist[0]});
      chk("pix8", {24'd0, bus.pix8}, {24'd0, hist[1]});
      chk("pix9", {24'd0, bus.pix9}, {24'd0, hist[2]});
      if (exp_ov) begin
         for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
               chk($sformatf("win_r%0d_c%0d_pix%0d", r, c, 3 * i + j + 1),
                   {24'd0, pix_at(3 * i + j + 1)},
                   {24'd0, img[r - 2 + i][c - 2 + j]});
      end
      if (bus.out_valid === 1'b1) nwin++;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst          = 1'b1;
      bus.in_valid = 1'b1;
      bus.in_pix   = 8'hAA;
`ifdef FRAME_SYNC_EN
      bus.sof      = 1'b0;
`endif
      @(posedge clk);
      #1;
      chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
      for (int k = 1; k <= 9; k++)
         chk($sformatf("rst_pix%0d", k), {24'd0, pix_at(k)}, 32'd0);
      rst          = 1'b0;
      bus.in_valid = 1'b0;
      idx          = 0;
      for (int k = 0; k < 3; k++) hist[k] = 8'd0;
   endtask

   task automatic ramp(input int n, input bit gaps);
      for (int k = 0; k < n; k++) begin
         step(1'b1, 8'(k % (W * H)), 1'b0);
         if (gaps) step(1'b0, 8'hEE, 1'b0);
      end
   endtask

   initial begin
      bus.in_valid = 1'b0;
      bus.in_pix   = 8'd0;
`ifdef FRAME_SYNC_EN
      bus.sof      = 1'b0;
`endif
      for (int k = 0; k < 3; k++) hist[k] = 8'd0;
      repeat (2) @(posedge clk);

      do_reset();
      nwin = 0;
      ramp(W * H, 1'b0);
      chk("ramp_windows", nwin, 2);

      nwin = 0;
      ramp(W * H, 1'b1);
      chk("gap_windows", nwin, 2);

      nwin = 0;
      ramp(2 * W * H, 1'b0);
      chk("b2b_windows", nwin, 4);

      nwin = 0;
      ramp(6, 1'b0);
      do_reset();
      nwin = 0;
      ramp(W * H, 1'b0);
      chk("after_rst_windows", nwin, 2);

      for (int k = 0; k < 400; k++)
         step($urandom_range(0, 3) != 0, 8'($urandom), 1'b0);

`ifdef FRAME_SYNC_EN
      do_reset();
      ramp(6, 1'b0);
      nwin = 0;
      step(1'b1, 8'd0, 1'b1);
      for (int k = 1; k < W * H; k++) step(1'b1, 8'(k), 1'b0);
      ramp(W * H, 1'b0);
      chk("sof_windows", nwin, 4);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/window3x3_gen.md
WINDOW3X3_GEN -- requirements
Module: window3x3_gen

Interface
REQ-001 Parameter: IMG_WIDTH, default 640, pixels per line (range 3..4096).
REQ-002 Parameter: IMG_HEIGHT, default 480, lines per frame (range 3..4096).
REQ-003 Parameter: DATA_W, default 8, pixel width in bits.
REQ-004 Port: clk  input  1  sole clock; all logic on rising edge.
REQ-005 Port: rst  input  1  synchronous, active-high reset.
REQ-006 Port: in_valid  input  1  in_pix is a new raster-order pixel this cycle.
REQ-007 Port: in_pix  input  DATA_W  incoming pixel.
REQ-008 Ports: pix1..pix9  output  DATA_W each  3x3 window in row-major order.
- pix1..pix3: oldest line, left to right.
- pix7..pix9: newest line; pix9 is the newest pixel.
REQ-009 Port: out_valid  output  1  pix1..pix9 hold a new, fully interior window.

Function
REQ-010 Raster order: column counter col runs 0..IMG_WIDTH-1 and advances only on in_valid; at IMG_WIDTH-1 it wraps to 0 and row increments.
REQ-011 row runs 0..IMG_HEIGHT-1; after pixel (IMG_HEIGHT-1, IMG_WIDTH-1) both counters wrap to 0 (next frame).
REQ-012 Two line buffers of depth IMG_WIDTH hold the previous line and the line before it; read and write are indexed by col.
REQ-013 On each accepted pixel, the window shifts left by one column and loads the new right column: pix3 = line-2 value, pix6 = line-1 value, pix9 = in_pix.
- Same cycle: the line-1 value is written into line buffer 2 and in_pix into line buffer 1 at index col.
REQ-014 Window outputs and out_valid are registered; latency is 1 clk from the accepted pixel to its appearance in pix9.
REQ-015 out_valid = 1 exactly one cycle after accepting a pixel with row >= 2 and col >= 2; otherwise 0.
- The window centre is then at (row-1, col-1).
REQ-016 When in_valid = 0: counters, line buffers and pix1..pix9 hold; out_valid = 0 the next cycle.
REQ-017 No backpressure: every in_valid pixel is accepted, and the downstream stage consumes every out_valid window.
REQ-018 Windows never span a line boundary: out_valid stays 0 for col 0 and col 1 of every line.
- Stale pix contents at those positions are don't-care.
REQ-019 Windows never span a frame boundary: row < 2 gates out_valid, so stale line-buffer data is never flagged valid.

Reset
REQ-020 On rst = 1 at a clk edge: col = 0, row = 0, out_valid = 0, pix1..pix9 = 0.
REQ-021 Line buffer contents are not reset; REQ-019 guarantees they are never exposed as valid.
REQ-022 rst has priority over in_valid; a pixel presented during rst is discarded.
REQ-023 Reset mid-frame restarts at (0,0); the next accepted pixel is treated as frame origin.

Configuration
REQ-024 Macro FRAME_SYNC_EN, when defined, adds port sof  input  1  start of frame, qualified by in_valid.
REQ-025 With FRAME_SYNC_EN: in_valid & sof forces the pixel to position (0,0) regardless of counter state; counters then continue from (0,1).
REQ-026 Without FRAME_SYNC_EN: no sof port; frame alignment comes only from rst and counter wrap (REQ-011).

Structure
REQ-027 A shared package holds DATA_W default, counter width function/constant (clog2 of 4096), and default IMG_WIDTH/IMG_HEIGHT constants.
REQ-028 One sub-module, line_buf: single-clock, depth IMG_WIDTH, one write port and one read port at the same index, read-before-write, instantiated twice.

Verification (IMG_WIDTH=4, IMG_HEIGHT=3, pixel value = row*4+col, in_valid continuous)
REQ-029 Ramp frame -> out_valid high exactly twice per frame.
- First window: pix1..pix9 = 0,1,2,4,5,6,8,9,10.
- Second window: 1,2,3,5,6,7,9,10,11.
REQ-030 Same frame with in_valid toggling 1,0,1,0 -> identical two windows; out_valid never high on an in_valid=0-following cycle; outputs hold during gaps.
REQ-031 Two back-to-back frames -> second frame again yields exactly the two windows of REQ-029; no window mixes frame 1 and frame 2 data.
REQ-032 rst asserted after pixel 6 of a frame, then a full frame restarted -> outputs 0 and out_valid 0 after rst; exactly the two windows of REQ-029 follow.
REQ-033 FRAME_SYNC_EN: sof with pixel at counter position (1,2) -> that pixel is treated as (0,0); the next frame's windows match REQ-029.
REQ-034 Without FRAME_SYNC_EN: a build check confirms no sof port exists.
